// File: rtl/pipe_ctrl_n_if.sv
// Request/status bundle between the pipeline stages (master) and the hazard controller (slave).
// Widths follow the stage count and the stall-counter width of the attached controller.
interface pipe_ctrl_n_if #(
   parameter int unsigned NSTAGES = 5,
   parameter int unsigned CNT_W   = 16
);
   logic [NSTAGES-1:0] stallreq;
   logic               mdu_start;
   logic               mdu_done;
   logic               flush_req;
   logic [31:0]        flush_pc;

   logic [NSTAGES:0]   stall;
   logic [NSTAGES-1:0] flush;
   logic               new_pc_valid;
   logic [31:0]        new_pc;
   logic               mdu_busy;
   logic               mdu_timeout;
   logic [CNT_W-1:0]   stall_cycles;

   modport master (
      output stallreq, mdu_start, mdu_done, flush_req, flush_pc,
      input  stall, flush, new_pc_valid, new_pc, mdu_busy, mdu_timeout, stall_cycles
   );

   modport slave (
      input  stallreq, mdu_start, mdu_done, flush_req, flush_pc,
      output stall, flush, new_pc_valid, new_pc, mdu_busy, mdu_timeout, stall_cycles
   );
endinterface

// File: rtl/pipe_ctrl_n.sv
// Pipeline hazard controller: prefix stall bus, multi-cycle-unit wait sequencing,
// timed flush with redirect PC, and a saturating stall-cycle counter.
module pipe_ctrl_n #(
   parameter int unsigned NSTAGES      = 5,
   parameter int unsigned MDU_STAGE    = 2,
   parameter int unsigned MDU_TIMEOUT  = 64,
   parameter int unsigned FLUSH_CYCLES = 1,
   parameter int unsigned CNT_W        = 16
) (
   input logic         clk,
   input logic         rst,
   pipe_ctrl_n_if.slave bus
);

   localparam int unsigned TW = $clog2(MDU_TIMEOUT + FLUSH_CYCLES + 1);

   typedef enum logic [1:0] {
      StIdle,
      StMduWait,
      StFlush
   } state_e;

   state_e             state_q, state_d;
   logic [TW-1:0]      timer_q, timer_d;
   logic [31:0]        new_pc_q, new_pc_d;
   logic               timeout_q, timeout_d;
   logic [CNT_W-1:0]   cnt_q;

   logic [NSTAGES-1:0] mdu_bit;
   logic [NSTAGES-1:0] req_eff;
   logic [NSTAGES:0]   stall_pre;
   logic [NSTAGES:0]   stall_int;

   always_comb begin
      mdu_bit            = '0;
      mdu_bit[MDU_STAGE] = 1'b1;
   end

   // The wait's own hold is dropped on the done cycle so the result can advance.
   always_comb begin
      req_eff = bus.stallreq;
      if (state_q == StMduWait && !bus.mdu_done) begin
         req_eff = bus.stallreq | mdu_bit;
      end
   end

   // stall[j] is set when any request sits at stage j-1 or later (stall[0] on any request).
   always_comb begin
      stall_pre = '0;
      for (int unsigned j = 0; j <= NSTAGES; j++) begin
         for (int unsigned i = 0; i < NSTAGES; i++) begin
            if (req_eff[i] && (i + 1 >= j)) begin
               stall_pre[j] = 1'b1;
            end
         end
      end
   end

   assign stall_int = (state_q == StFlush) ? '0 : stall_pre;

   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      new_pc_d  = new_pc_q;
      timeout_d = timeout_q;
      unique case (state_q)
         StIdle: begin
            if (bus.flush_req) begin
               state_d  = StFlush;
               new_pc_d = bus.flush_pc;
               timer_d  = TW'(FLUSH_CYCLES);
            end else if (bus.mdu_start) begin
               state_d = StMduWait;
               timer_d = '0;
            end
         end
         StMduWait: begin
            timer_d = timer_q + 1'b1;
            if (bus.flush_req) begin
               state_d  = StFlush;
               new_pc_d = bus.flush_pc;
               timer_d  = TW'(FLUSH_CYCLES);
            end else if (bus.mdu_done) begin
               state_d = StIdle;
            end else if (timer_q == TW'(MDU_TIMEOUT - 1)) begin
               state_d   = StIdle;
               timeout_d = 1'b1;
            end
         end
         StFlush: begin
            timer_d = timer_q - 1'b1;
            if (timer_q <= TW'(1)) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
            timer_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= StIdle;
         timer_q   <= '0;
         new_pc_q  <= '0;
         timeout_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         new_pc_q  <= new_pc_d;
         timeout_q <= timeout_d;
         if (stall_int[0] && cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   // Outputs are forced quiet while reset is held so a mid-operation reset is seen at once.
   always_comb begin
      bus.stall        = rst ? stall_int : '0;
      bus.flush        = (rst && state_q == StFlush) ? '1 : '0;
      bus.new_pc_valid = rst && state_q == StFlush && timer_q == TW'(FLUSH_CYCLES);
      bus.new_pc       = rst ? new_pc_q : '0;
      bus.mdu_busy     = rst && state_q == StMduWait;
      bus.mdu_timeout  = rst && timeout_q;
      bus.stall_cycles = rst ? cnt_q : '0;
   end

endmodule

// File: tb/tb_pipe_ctrl_n.sv
// Scoreboard bench for pipe_ctrl_n: the driver queues one hand-derived expectation per cycle,
// a negedge monitor pops and compares it against the live outputs.
module tb_pipe_ctrl_n;

   typedef struct {
      logic [5:0]  stall;
      logic [4:0]  flush;
      logic        npv;
      logic [31:0] npc;
      logic        busy;
      logic        tmo;
      logic [3:0]  cnt;
      int          phase;
      int          cyc;
   } exp_t;

   logic clk;
   logic rst;

   pipe_ctrl_n_if #(.NSTAGES(5), .CNT_W(4)) bus ();

   pipe_ctrl_n #(
      .NSTAGES     (5),
      .MDU_STAGE   (2),
      .MDU_TIMEOUT (64),
      .FLUSH_CYCLES(2),
      .CNT_W       (4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   exp_t        sb[$];
   int          n_pass  = 0;
   int          n_total = 0;
   int          cyc_no  = 0;
   int          phase   = 0;
   logic [31:0] e_npc   = '0;
   logic        e_tmo   = 1'b0;
   logic [3:0]  cnt_m   = '0;

   exp_t m;
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         m = sb.pop_front();
         n_total++;
         if (bus.stall !== m.stall || bus.flush !== m.flush || bus.new_pc_valid !== m.npv ||
             bus.new_pc !== m.npc || bus.mdu_busy !== m.busy || bus.mdu_timeout !== m.tmo ||
             bus.stall_cycles !== m.cnt) begin
            $display("FAIL phase%0d cyc%0d: got stall=%b flush=%b npv=%b npc=%h busy=%b tmo=%b cnt=%h ; want stall=%b flush=%b npv=%b npc=%h busy=%b tmo=%b cnt=%h",
                     m.phase, m.cyc, bus.stall, bus.flush, bus.new_pc_valid, bus.new_pc,
                     bus.mdu_busy, bus.mdu_timeout, bus.stall_cycles, m.stall, m.flush, m.npv,
                     m.npc, m.busy, m.tmo, m.cnt);
         end else begin
            n_pass++;
         end
      end
   end

   // Queue this cycle's expected outputs, advance the counter model, then move to the next cycle.
   task automatic step(input logic [5:0] s, input logic [4:0] f, input logic v, input logic b);
      exp_t e;
      e.stall = s;
      e.flush = f;
      e.npv   = v;
      e.busy  = b;
      e.npc   = rst ? e_npc : 32'h0;
      e.tmo   = rst & e_tmo;
      e.cnt   = rst ? cnt_m : 4'h0;
      e.phase = phase;
      e.cyc   = cyc_no;
      sb.push_back(e);
      if (!rst) begin
         cnt_m = 4'h0;
         e_npc = 32'h0;
         e_tmo = 1'b0;
      end else if (s[0] && cnt_m != 4'hF) begin
         cnt_m = cnt_m + 4'h1;
      end
      cyc_no++;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst           = 1'b0;
      bus.stallreq  = 5'b11111;
      bus.mdu_start = 1'b0;
      bus.mdu_done  = 1'b0;
      bus.flush_req = 1'b0;
      bus.flush_pc  = 32'h0;
      @(posedge clk);
      #1;

      // Reset held with every stage requesting a hold.
      phase = 1;
      step(6'b000000, 5'b00000, 1'b0, 1'b0);
      step(6'b000000, 5'b00000, 1'b0, 1'b0);
      rst = 1'b1;
      bus.stallreq = 5'b00000;
      step(6'b000000, 5'b00000, 1'b0, 1'b0);

      // Prefix decode of several request patterns.
      phase = 2;
      bus.stallreq = 5'b00100;
      for (int i = 0; i < 3; i++) step(6'b001111, 5'b00000, 1'b0, 1'b0);
      bus.stallreq = 5'b00001;
      step(6'b000011, 5'b00000, 1'b0, 1'b0);
      bus.stallreq = 5'b10000;
      step(6'b111111, 5'b00000, 1'b0, 1'b0);
      bus.stallreq = 5'b01010;
      step(6'b011111, 5'b00000, 1'b0, 1'b0);
      bus.stallreq = 5'b00000;
      step(6'b000000, 5'b00000, 1'b0, 1'b0);

      // MDU op completing 10 cycles after issue.
      phase = 3;
      bus.mdu_start = 1'b1;
      step(6'b000000, 5'b00000, 1'b0, 1'b0);
      bus.mdu_start = 1'b0;
      for (int i = 0; i < 9; i++) step(6'b001111, 5'b00000, 1'b0, 1'b1);
      bus.mdu_done = 1'b1;
      step(6'b000000, 5'b00000, 1'b0, 1'b1);
      bus.mdu_done = 1'b0;
      step(6'b000000, 5'b00000, 1'b0, 1'b0);

      // flush_req together with mdu_done during the wait: flush wins, no timeout.
      phase = 4;
      bus.mdu_start = 1'b1;
      step(6'b000000, 5'b00000, 1'b0, 1'b0);
      bus.mdu_start = 1'b0;
      for (int i = 0; i < 3; i++) step(6'b001111, 5'b00000, 1'b0, 1'b1);
      bus.flush_req = 1'b1;
      bus.mdu_done  = 1'b1;
      bus.flush_pc  = 32'h0000_1234;
      step(6'b000000, 5'b00000, 1'b0, 1'b1);
      bus.flush_req = 1'b0;
      bus.mdu_done  = 1'b0;
      e_npc = 32'h0000_1234;
      step(6'b000000, 5'b11111, 1'b1, 1'b0);
      step(6'b000000, 5'b11111, 1'b0, 1'b0);
      step(6'b000000, 5'b00000, 1'b0, 1'b0);

      // Redirect flush with a held stall request; flush_req and mdu_start ignored in FLUSH.
      phase = 5;
      bus.stallreq  = 5'b00100;
      bus.flush_req = 1'b1;
      bus.flush_pc  = 32'hBFC0_0380;
      step(6'b001111, 5'b00000, 1'b0, 1'b0);
      bus.flush_req = 1'b0;
      e_npc = 32'hBFC0_0380;
      step(6'b000000, 5'b11111, 1'b1, 1'b0);
      bus.flush_req = 1'b1;
      bus.mdu_start = 1'b1;
      bus.flush_pc  = 32'hDEAD_0000;
      step(6'b000000, 5'b11111, 1'b0, 1'b0);
      bus.flush_req = 1'b0;
      bus.mdu_start = 1'b0;
      step(6'b001111, 5'b00000, 1'b0, 1'b0);
      step(6'b001111, 5'b00000, 1'b0, 1'b0);
      bus.stallreq = 5'b00000;
      step(6'b000000, 5'b00000, 1'b0, 1'b0);

      // flush_req and mdu_start together in IDLE.
      phase = 6;
      bus.flush_req = 1'b1;
      bus.mdu_start = 1'b1;
      bus.flush_pc  = 32'h8000_0000;
      step(6'b000000, 5'b00000, 1'b0, 1'b0);
      bus.flush_req = 1'b0;
      bus.mdu_start = 1'b0;
      e_npc = 32'h8000_0000;
      step(6'b000000, 5'b11111, 1'b1, 1'b0);
      step(6'b000000, 5'b11111, 1'b0, 1'b0);
      step(6'b000000, 5'b00000, 1'b0, 1'b0);

      // MDU op that never completes: abort after 64 wait cycles, sticky timeout.
      phase = 7;
      bus.mdu_start = 1'b1;
      step(6'b000000, 5'b00000, 1'b0, 1'b0);
      bus.mdu_start = 1'b0;
      for (int i = 0; i < 64; i++) step(6'b001111, 5'b00000, 1'b0, 1'b1);
      e_tmo = 1'b1;
      step(6'b000000, 5'b00000, 1'b0, 1'b0);
      bus.mdu_done = 1'b1;
      step(6'b000000, 5'b00000, 1'b0, 1'b0);
      bus.mdu_done = 1'b0;
      step(6'b000000, 5'b00000, 1'b0, 1'b0);

      // Reset in the middle of a flush.
      phase = 8;
      bus.flush_req = 1'b1;
      bus.flush_pc  = 32'h0000_0100;
      step(6'b000000, 5'b00000, 1'b0, 1'b0);
      bus.flush_req = 1'b0;
      e_npc = 32'h0000_0100;
      step(6'b000000, 5'b11111, 1'b1, 1'b0);
      rst = 1'b0;
      step(6'b000000, 5'b00000, 1'b0, 1'b0);
      rst = 1'b1;
      step(6'b000000, 5'b00000, 1'b0, 1'b0);

      // Reset in the middle of an MDU wait.
      phase = 9;
      bus.mdu_start = 1'b1;
      step(6'b000000, 5'b00000, 1'b0, 1'b0);
      bus.mdu_start = 1'b0;
      step(6'b001111, 5'b00000, 1'b0, 1'b1);
      step(6'b001111, 5'b00000, 1'b0, 1'b1);
      rst = 1'b0;
      step(6'b000000, 5'b00000, 1'b0, 1'b0);
      rst = 1'b1;
      step(6'b000000, 5'b00000, 1'b0, 1'b0);
      step(6'b000000, 5'b00000, 1'b0, 1'b0);

      // Hold a stall for 20 cycles so the 4-bit counter saturates at 4'hF.
      phase = 10;
      bus.stallreq = 5'b00001;
      for (int i = 0; i < 20; i++) step(6'b000011, 5'b00000, 1'b0, 1'b0);
      bus.stallreq = 5'b00000;
      step(6'b000000, 5'b00000, 1'b0, 1'b0);
      step(6'b000000, 5'b00000, 1'b0, 1'b0);

      for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
      if (sb.size() != 0) begin
         n_total++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
